// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
// Shared types and operation-decoding helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op inside {DIV, DIVU, REM, REMU});
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op inside {REM, REMU});
  endfunction

  function automatic logic a_signed(input md_op_e op);
    return (op inside {MULH, MULHSU, DIV, REM});
  endfunction

  function automatic logic b_signed(input md_op_e op);
    return (op inside {MULH, DIV, REM});
  endfunction

endpackage

// File: rtl/muldiv_special_detect.sv
`timescale 1ns/1ps
// Flags divide-by-zero and signed division overflow and supplies the
// architecturally defined result so those cases skip the iterative datapath.
module muldiv_special_detect import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  md_op_e          op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  logic div_zero_s;
  logic overflow_s;

  assign div_zero_s = is_div(op) && (src_b == {XLEN{1'b0}});
  assign overflow_s = is_div(op) && a_signed(op)
                      && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (src_b == {XLEN{1'b1}});
  assign is_special = div_zero_s || overflow_s;

  // Select the fixed result for whichever special case fired.
  always_comb begin
    special_result = {XLEN{1'b0}};
    if (div_zero_s) begin
      special_result = is_rem(op) ? src_a : {XLEN{1'b1}};
    end else if (overflow_s) begin
      special_result = is_rem(op) ? {XLEN{1'b0}} : src_a;
    end else begin
      special_result = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready request side and a held result.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [2:0]      i_MDCtrl,
  input  logic [XLEN-1:0] i_SrcA,
  input  logic [XLEN-1:0] i_SrcB,
  input  logic            i_Flush,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Zero
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e        state_r;
  md_op_e           op_r;
  md_op_e           in_op_s;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_r;
  // hi/lo form the product accumulator for multiplies and the
  // remainder/quotient pair for divides; opb holds multiplicand or divisor.
  logic [XLEN-1:0]  hi_r;
  logic [XLEN-1:0]  lo_r;
  logic [XLEN-1:0]  opb_r;

  logic             sign_a_s;
  logic             sign_b_s;
  logic [XLEN-1:0]  mag_a_s;
  logic [XLEN-1:0]  mag_b_s;
  logic             special_s;
  logic [XLEN-1:0]  special_res_s;

  logic [XLEN:0]    mul_sum_s;
  logic [XLEN:0]    div_shift_s;
  logic [XLEN-1:0]  div_sub_s;
  logic             div_ge_s;
  logic [XLEN-1:0]  hi_nxt_s;
  logic [XLEN-1:0]  lo_nxt_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]  quo_fix_s;
  logic [XLEN-1:0]  rem_fix_s;
  logic [XLEN-1:0]  calc_res_s;

  assign in_op_s  = md_op_e'(i_MDCtrl);
  assign sign_a_s = a_signed(in_op_s) && i_SrcA[XLEN-1];
  assign sign_b_s = b_signed(in_op_s) && i_SrcB[XLEN-1];
  // The most-negative value's magnitude 2^(XLEN-1) is exact as an unsigned XLEN-bit value.
  assign mag_a_s  = sign_a_s ? -i_SrcA : i_SrcA;
  assign mag_b_s  = sign_b_s ? -i_SrcB : i_SrcB;

  muldiv_special_detect #(.XLEN(XLEN)) u_special (
    .op             (in_op_s),
    .src_a          (i_SrcA),
    .src_b          (i_SrcB),
    .is_special     (special_s),
    .special_result (special_res_s)
  );

  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
  assign div_shift_s = {hi_r, lo_r[XLEN-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opb_r});
  assign div_sub_s   = div_shift_s[XLEN-1:0] - opb_r;

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (is_div(op_r)) begin
      if (div_ge_s) begin
        hi_nxt_s = div_sub_s;
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt_s = div_shift_s[XLEN-1:0];
        lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt_s = mul_sum_s[XLEN:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  assign prod_fix_s = neg_r ? -{hi_nxt_s, lo_nxt_s} : {hi_nxt_s, lo_nxt_s};
  assign quo_fix_s  = neg_r ? -lo_nxt_s : lo_nxt_s;
  assign rem_fix_s  = neg_r ? -hi_nxt_s : hi_nxt_s;

  // Pick the sign-corrected result field for the latched operation.
  always_comb begin
    calc_res_s = {XLEN{1'b0}};
    case (op_r)
      MUL:                 calc_res_s = prod_fix_s[XLEN-1:0];
      MULH, MULHSU, MULHU: calc_res_s = prod_fix_s[2*XLEN-1:XLEN];
      DIV, DIVU:           calc_res_s = quo_fix_s;
      REM, REMU:           calc_res_s = rem_fix_s;
      default:             calc_res_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r  <= IDLE;
      op_r     <= MUL;
      cnt_r    <= {CNT_W{1'b0}};
      neg_r    <= 1'b0;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      opb_r    <= {XLEN{1'b0}};
      o_Ready  <= 1'b1;
      o_Valid  <= 1'b0;
      o_Result <= {XLEN{1'b0}};
      o_Zero   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_Flush) begin
            o_Ready <= 1'b1;
          end else if (i_Valid) begin
            op_r    <= in_op_s;
            o_Ready <= 1'b0;
            if (special_s) begin
              o_Result <= special_res_s;
              o_Zero   <= (special_res_s == {XLEN{1'b0}});
              o_Valid  <= 1'b1;
              state_r  <= DONE;
            end else begin
              cnt_r   <= CNT_W'(XLEN-1);
              hi_r    <= {XLEN{1'b0}};
              lo_r    <= is_div(in_op_s) ? mag_a_s : mag_b_s;
              opb_r   <= is_div(in_op_s) ? mag_b_s : mag_a_s;
              neg_r   <= is_rem(in_op_s) ? sign_a_s : (sign_a_s ^ sign_b_s);
              state_r <= CALC;
            end
          end else begin
            o_Ready <= 1'b1;
          end
        end
        CALC: begin
          if (i_Flush) begin
            o_Ready <= 1'b1;
            state_r <= IDLE;
          end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
              o_Result <= calc_res_s;
              o_Zero   <= (calc_res_s == {XLEN{1'b0}});
              o_Valid  <= 1'b1;
              state_r  <= DONE;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (i_Flush || i_Ready) begin
            o_Valid <= 1'b0;
            o_Ready <= 1'b1;
            state_r <= IDLE;
          end else begin
            o_Valid <= 1'b1;
          end
        end
        default: begin
          o_Valid <= 1'b0;
          o_Ready <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops
// against a plain-arithmetic reference, backpressure, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  mdctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  muldiv_unit #(.XLEN(32)) dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_Valid  (in_valid),
    .o_Ready  (out_ready),
    .i_MDCtrl (mdctrl),
    .i_SrcA   (src_a),
    .i_SrcB   (src_b),
    .i_Flush  (flush),
    .o_Valid  (out_valid),
    .i_Ready  (in_ready),
    .o_Result (result),
    .o_Zero   (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    longint      q;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin q = sa * sb; p = q; return p[63:32]; end
      3'd2: begin q = sa * longint'(ub); p = q; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Waits for o_Ready, issues one request and reports the result and the number
  // of edges from the accept edge (inclusive) until o_Valid is seen.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output logic [31:0] res, output logic z,
                       output int lat, output logic ok);
    int w = 0;
    @(negedge clk);
    while (!out_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_ready = rdy;
    in_valid = 1'b1;
    mdctrl   = op;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    z   = zero;
    ok  = out_valid;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b result=%h zero=%b, required 1 0 00000000 0",
               out_ready, out_valid, result, zero);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    vec_t vecs[12] = '{
      '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 8'd33},
      '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 8'd33},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd33},
      '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd33},
      '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd33},
      '{3'd5, 32'h00000010, 32'h00000005, 32'h00000003, 8'd33},
      '{3'd7, 32'h0000000F, 32'h00000005, 32'h00000000, 8'd33},
      '{3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 8'd1},
      '{3'd6, 32'h00001234, 32'h00000000, 32'h00001234, 8'd1},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1}
    };
    logic [31:0] res;
    logic        z;
    logic        ok;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, res, z, lat, ok);
      total_cnt++;
      if (!ok || res !== vecs[i].exp || z !== (vecs[i].exp == 32'd0))
        $display("FAIL directed_%0d result: got %h zero=%b valid=%b, required %h zero=%b",
                 i, res, z, ok, vecs[i].exp, (vecs[i].exp == 32'd0));
      else pass_cnt++;
      total_cnt++;
      if (lat !== int'(vecs[i].lat))
        $display("FAIL directed_%0d latency: got %0d, required %0d", i, lat, vecs[i].lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [31:0] res;
    logic        z;
    logic        ok;
    int          lat;
    int          pick;
    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 32'd0;
      else if (pick == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (pick == 2) begin a = $urandom_range(0, 255); b = $urandom_range(0, 15); end
      else if (pick == 3) b = 32'($signed(-$urandom_range(1, 9)));
      exp = ref_model(op, a, b);
      do_op(op, a, b, 1'b1, res, z, lat, ok);
      total_cnt++;
      if (!ok || res !== exp || z !== (exp == 32'd0) || lat != ref_latency(op, a, b))
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h zero=%b lat=%0d, required %h zero=%b lat=%0d",
                 i, op, a, b, res, z, lat, exp, (exp == 32'd0), ref_latency(op, a, b));
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    logic [31:0] exp;
    logic [31:0] res;
    logic        z;
    logic        ok;
    int          lat;
    int          bad = 0;
    exp = ref_model(3'd1, a, b);
    do_op(3'd1, a, b, 1'b0, res, z, lat, ok);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (result !== exp || out_valid !== 1'b1 || out_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL backpressure_hold: %0d unstable cycles, last result=%h valid=%b ready=%b, required %h 1 0",
               bad, result, out_valid, out_ready, exp);
    else pass_cnt++;
    @(negedge clk);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1)
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", out_valid, out_ready);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    logic [31:0] res;
    logic        z;
    logic        ok;
    int          lat;
    int          seen = 0;
    prev = result;
    @(negedge clk);
    in_valid = 1'b1;
    mdctrl   = 3'd0;
    src_a    = $urandom;
    src_b    = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    total_cnt++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || result !== prev)
      $display("FAIL flush_calc: ready=%b valid=%b result=%h, required 1 0 %h",
               out_ready, out_valid, result, prev);
    else pass_cnt++;
    // A request coinciding with flush in IDLE must not be taken.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    mdctrl   = 3'd5;
    src_b    = 32'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen != 0 || out_ready !== 1'b1)
      $display("FAIL flush_no_result: valid seen %0d cycles, ready=%b, required 0 cycles ready=1",
               seen, out_ready);
    else pass_cnt++;
    do_op(3'd0, 32'd3, 32'd4, 1'b1, res, z, lat, ok);
    total_cnt++;
    if (!ok || res !== 32'h0000000C || lat != 33)
      $display("FAIL flush_followup: got %h lat=%0d valid=%b, required 0000000c lat=33", res, lat, ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        z;
    logic        ok;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1;
    mdctrl   = 3'd4;
    src_a    = 32'h7FFF1234;
    src_b    = 32'h00000013;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0)
      $display("FAIL reset_mid: ready=%b valid=%b result=%h zero=%b, required 1 0 00000000 0",
               out_ready, out_valid, result, zero);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd7, 32'd100, 32'd7, 1'b1, res, z, lat, ok);
    total_cnt++;
    if (!ok || res !== 32'd2 || z !== 1'b0)
      $display("FAIL reset_recover: got %h zero=%b valid=%b, required 00000002 0", res, z, ok);
    else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    mdctrl   = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
